// File: rtl/seq_unsdiv.sv
// ---------------------------------------------------------------------------
// seq_unsdiv
//   Iterative restoring integer divider for the ALU datapath. It computes
//   a / b and returns the quotient and the remainder. One subtractor is
//   shared across iterations, so one quotient bit is resolved per clock.
//   The opcode decoder talks to it through a start/busy/done handshake.
//
//   Optional feature macro: SIGNED_DIV_EN
//     undefined : unsigned division only, no sgn_i port
//     defined   : adds sgn_i. When sgn_i=1 the operands are two's
//                 complement, and a FIX state restores the result signs.
//
// Ports
//   clk_i    in   1      clock, rising edge
//   rst_i    in   1      synchronous, active-high reset
//   start_i  in   1      request, sampled only in IDLE
//   sgn_i    in   1      signed request (SIGNED_DIV_EN builds only)
//   a_i      in   WIDTH  dividend, captured on the accepting edge
//   b_i      in   WIDTH  divisor, captured on the accepting edge
//   quot_o   out  WIDTH  quotient, held from done until the next accept
//   rem_o    out  WIDTH  remainder, held from done until the next accept
//   busy_o   out  1      operation in flight
//   done_o   out  1      one-cycle pulse, results valid in that cycle
//   dz_o     out  1      divide-by-zero flag, updated together with done
//
// Timing (E0 = accepting edge): iterations run on E1..E_WIDTH, FIN is the
// cycle that follows, and done is seen in the cycle after E_WIDTH+1.
// SIGNED_DIV_EN adds one cycle for FIX. A zero divisor skips CALC, so done
// is seen in the cycle after E1.
// ---------------------------------------------------------------------------
module seq_unsdiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
`ifdef SIGNED_DIV_EN
  input  logic             sgn_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

`ifdef SIGNED_DIV_EN
  typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             dzPend_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
`ifdef SIGNED_DIV_EN
  logic             negQuot_q;
  logic             negRem_q;
`endif

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;

  // One restoring step. The full partial remainder is kept in the shift so
  // divisors with the MSB set still divide correctly. Because P < D always
  // holds, the WIDTH+1-bit difference is negative exactly when its top bit
  // is set.
  always_comb begin
    shifted = {p_q, q_q[WIDTH-1]};
    trial   = shifted - {1'b0, d_q};
    if (trial[WIDTH]) begin
      p_d = shifted[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end else begin
      p_d = trial[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  // Operand magnitudes fed to the unsigned core. The most-negative value
  // negates to itself, which still reads as the correct unsigned magnitude.
  always_comb begin
    aMag = a_i;
    bMag = b_i;
`ifdef SIGNED_DIV_EN
    if (sgn_i && a_i[WIDTH-1]) aMag = -a_i;
    if (sgn_i && b_i[WIDTH-1]) bMag = -b_i;
`endif
  end

  // Control FSM and datapath registers. Results and flags are written on
  // the edge that leaves FIN, so busy falls on the same edge that done
  // rises, and a start held high is accepted on the edge that ends the
  // done cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      p_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      dzPend_q  <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
`ifdef SIGNED_DIV_EN
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            dz_q   <= 1'b0;
            p_q    <= '0;
            d_q    <= b_i;
            cnt_q  <= '0;
`ifdef SIGNED_DIV_EN
            negQuot_q <= sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            negRem_q  <= sgn_i & a_i[WIDTH-1];
`endif
            // A zero divisor keeps the raw dividend so it can be returned
            // as the remainder.
            if (b_i == '0) begin
              q_q      <= a_i;
              dzPend_q <= 1'b1;
              state_q  <= FIN;
            end else begin
              q_q      <= aMag;
              d_q      <= bMag;
              dzPend_q <= 1'b0;
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
`ifdef SIGNED_DIV_EN
            state_q <= FIX;
`else
            state_q <= FIN;
`endif
          end
        end
`ifdef SIGNED_DIV_EN
        FIX: begin
          if (negQuot_q) q_q <= -q_q;
          if (negRem_q)  p_q <= -p_q;
          state_q <= FIN;
        end
`endif
        FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
          if (dzPend_q) begin
            quot_q <= '1;
            rem_q  <= q_q;
            dz_q   <= 1'b1;
          end else begin
            quot_q <= q_q;
            rem_q  <= p_q;
            dz_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign dz_o   = dz_q;

endmodule

// File: tb/tb_seq_unsdiv.sv
// ---------------------------------------------------------------------------
// tb_seq_unsdiv
//   Self-checking bench for seq_unsdiv. It applies a fixed vector table,
//   hand-written multi-cycle sequences (ignored start, mid-operation reset,
//   back-to-back operation) and random operands. Random results come from a
//   reference model that uses plain integer division.
// ---------------------------------------------------------------------------
module tb_seq_unsdiv;

  localparam int W = 8;
`ifdef SIGNED_DIV_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif
  localparam int DZ_LAT = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         busy;
  logic         done;
  logic         dz;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[$];

  seq_unsdiv #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
`ifdef SIGNED_DIV_EN
    .sgn_i   (sgn),
`endif
    .a_i     (a),
    .b_i     (b),
    .quot_o  (quot),
    .rem_o   (rem),
    .busy_o  (busy),
    .done_o  (done),
    .dz_o    (dz)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Compare one value and report it when it differs.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model built from the arithmetic definition of division.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic dzo);
    int sa, sb;
    if (bv == 0) begin
      q = '1; r = av; dzo = 1'b1;
    end else if (!s) begin
      q = W'(int'(av) / int'(bv));
      r = W'(int'(av) % int'(bv));
      dzo = 1'b0;
    end else begin
      sa = int'($signed(av));
      sb = int'($signed(bv));
      q = W'(sa / sb);
      r = W'(sa % sb);
      dzo = 1'b0;
    end
  endfunction

  // Run one operation with a one-cycle start pulse. The operand inputs are
  // scrambled after the accepting edge. edges is the index n of the edge
  // E_n after which done was first seen, or -1 when it never arrived.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                               output logic [W-1:0] qo, output logic [W-1:0] ro,
                               output logic dzo, output int edges);
    @(negedge clk);
    a = av; b = bv; sgn = sv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sgn = 1'($urandom);
    edges = -1;
    qo = '0; ro = '0; dzo = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin
        edges = n;
        qo = quot; ro = rem; dzo = dz;
        checkOutput("busyWithDone", busy, 0);
        break;
      end
    end
    if (edges < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout: got no done expected one within 40 cycles");
    end else begin
      @(negedge clk);
      checkOutput("donePulseWidth", done, 0);
      checkOutput("quotHeld", quot, qo);
    end
  endtask

  initial begin
    logic [W-1:0] gq, gr, eq, er;
    logic         gdz, edz;
    int           edges;
    int           doneCnt;
    int           t0, t1;
    logic [W-1:0] ra, rb;
    logic         rs;

    vecs.push_back('{8'd100, 8'd7,   1'b0, 8'd14,  8'd2,  1'b0});
    vecs.push_back('{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,  1'b0});
    vecs.push_back('{8'd3,   8'd200, 1'b0, 8'd0,   8'd3,  1'b0});
    vecs.push_back('{8'd5,   8'd0,   1'b0, 8'hFF,  8'd5,  1'b1});
    vecs.push_back('{8'd20,  8'd4,   1'b0, 8'd5,   8'd0,  1'b0});
    vecs.push_back('{8'd200, 8'd9,   1'b0, 8'd22,  8'd2,  1'b0});
    vecs.push_back('{8'd255, 8'd200, 1'b0, 8'd1,   8'd55, 1'b0});
    vecs.push_back('{8'd0,   8'd13,  1'b0, 8'd0,   8'd0,  1'b0});
    vecs.push_back('{8'd128, 8'd255, 1'b0, 8'd0,   8'd128, 1'b0});
`ifdef SIGNED_DIV_EN
    vecs.push_back('{8'h9C,  8'd7,   1'b1, 8'hF2,  8'hFE, 1'b0});
    vecs.push_back('{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00, 1'b0});
    vecs.push_back('{8'd100, 8'hF9,  1'b1, 8'hF2,  8'd2,  1'b0});
    vecs.push_back('{8'hFB,  8'h00,  1'b1, 8'hFF,  8'hFB, 1'b1});
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetQuot", quot, 0);
    checkOutput("resetRem", rem, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetDz", dz, 0);

    // Table-driven vectors, including latency of normal and zero divisor.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, gq, gr, gdz, edges);
      checkOutput($sformatf("vecQuot[%0d]", i), gq, vecs[i].q);
      checkOutput($sformatf("vecRem[%0d]", i), gr, vecs[i].r);
      checkOutput($sformatf("vecDz[%0d]", i), gdz, vecs[i].dz);
      checkOutput($sformatf("vecLatency[%0d]", i), edges, vecs[i].dz ? DZ_LAT : LAT);
    end

    // Start pulsed mid-operation with other operands must be ignored.
    @(negedge clk);
    a = 8'd100; b = 8'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("busyInFlight", busy, 1);
    repeat (2) @(negedge clk);
    a = 8'd9; b = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    doneCnt = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done) begin
        doneCnt++;
        gq = quot; gr = rem;
      end
    end
    checkOutput("ignoredStartDones", doneCnt, 1);
    checkOutput("ignoredStartQuot", gq, 14);
    checkOutput("ignoredStartRem", gr, 2);
    applyStimulus(8'd9, 8'd3, 1'b0, gq, gr, gdz, edges);
    checkOutput("afterIgnoredQuot", gq, 3);
    checkOutput("afterIgnoredRem", gr, 0);

    // Reset in the middle of an operation aborts it silently.
    @(negedge clk);
    a = 8'd200; b = 8'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortQuot", quot, 0);
    checkOutput("abortRem", rem, 0);
    doneCnt = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("abortNoDone", doneCnt, 0);
    applyStimulus(8'd200, 8'd9, 1'b0, gq, gr, gdz, edges);
    checkOutput("restartQuot", gq, 22);
    checkOutput("restartRem", gr, 2);

    // Start held high: operations follow each other back to back.
    @(negedge clk);
    a = 8'd100; b = 8'd7; sgn = 1'b0; start = 1'b1;
    doneCnt = 0; t0 = -1; t1 = -1;
    for (int n = 0; n < 40 && doneCnt < 2; n++) begin
      @(negedge clk);
      if (done) begin
        doneCnt++;
        if (doneCnt == 1) t0 = n; else t1 = n;
        checkOutput("b2bQuot", quot, 14);
      end
    end
    start = 1'b0;
    checkOutput("b2bDones", doneCnt, 2);
    checkOutput("b2bGap", t1 - t0, LAT + 1);
    repeat (15) @(negedge clk);

    // Random operands against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
`ifdef SIGNED_DIV_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      model(ra, rb, rs, eq, er, edz);
      applyStimulus(ra, rb, rs, gq, gr, gdz, edges);
      checkOutput($sformatf("rndQuot %0d/%0d", ra, rb), gq, eq);
      checkOutput($sformatf("rndRem %0d/%0d", ra, rb), gr, er);
      checkOutput($sformatf("rndDz %0d/%0d", ra, rb), gdz, edz);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
